// File: rtl/mdr_load_ctrl.sv
// rtl/mdr_load_ctrl.sv - load-path controller: range/alignment check, fixed-latency read, byte/half alignment into MDR
module mdr_load_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int MEM_BYTES   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loadReq,
  input  logic [1:0]  loadSel,
  input  logic [31:0] addrIn,
  output logic [31:0] memAddr,
  output logic        memRead,
  input  logic [31:0] memData,
  output logic [31:0] mdrOut,
  output logic [1:0]  exceptionControl,
  output logic        loadDone,
  output logic        busy
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DONE,
    S_EXC
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    addr_lo;   // only the byte lane of the latched address matters after acceptance
  logic [1:0]    sel_q;
  logic          out_of_range;
  logic          misaligned;
  logic [1:0]    exc_code;
  logic [31:0]   aligned;

  // Request checks; range wins over alignment, so range is tested first
  always_comb begin
    out_of_range = (addrIn >= 32'(MEM_BYTES));
    misaligned   = ((loadSel == 2'b01) && addrIn[0]) ||
                   (loadSel[1] && (addrIn[1:0] != 2'b00));
    exc_code     = 2'b00;
    if (out_of_range) begin
      exc_code = 2'b10;
    end else if (misaligned) begin
      exc_code = 2'b01;
    end
  end

  // Shift the addressed byte/halfword of the memory word down to the LSBs
  always_comb begin
    aligned = memData;
    case (sel_q)
      2'b00:   aligned = (memData >> {addr_lo, 3'b000}) & 32'h0000_00FF;
      2'b01:   aligned = (memData >> {addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
      default: aligned = memData;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and strobe outputs
  always_comb begin
    state_nx = state;
    memRead  = 1'b0;
    loadDone = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (loadReq) begin
          state_nx = (exc_code != 2'b00) ? S_EXC : S_READ;
        end
      end
      S_READ: begin
        memRead  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // the cycle in which the counter steps to zero carries valid memData
        if (cnt <= CW'(1)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        loadDone = 1'b1;
        state_nx = S_IDLE;
      end
      S_EXC: begin
        loadDone = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, memory address, latency counter, MDR and exception code
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt              <= '0;
      addr_lo          <= 2'b00;
      sel_q            <= 2'b00;
      memAddr          <= 32'h0;
      mdrOut           <= 32'h0;
      exceptionControl <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (loadReq) begin
            addr_lo          <= addrIn[1:0];
            sel_q            <= loadSel;
            exceptionControl <= exc_code;
            if (exc_code == 2'b00) begin
              memAddr <= {addrIn[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          cnt <= CW'(MEM_LATENCY);
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (state_nx == S_DONE) begin
            mdrOut <= aligned;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
